// File: rtl/axi_wr_cmd_queue.sv
// Write-command queue: buffers addr/data/strb commands and issues them one at a
// time to an AXI write master. Optional error counter under AXI_WR_CMD_ERR_CNT_EN.
module axi_wr_cmd_queue #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  input  logic                      i_push,
  input  logic [ADDR_W-1:0]         i_addr,
  input  logic [DATA_W-1:0]         i_data,
  input  logic [DATA_W/8-1:0]       i_strb,
  output logic                      o_full,
  output logic                      o_empty,
  output logic [$clog2(DEPTH):0]    o_count,
  output logic                      o_ovf,
  output logic                      o_wr,
  output logic [ADDR_W-1:0]         o_addrin,
  output logic [DATA_W-1:0]         o_din,
  output logic [DATA_W/8-1:0]       o_strb,
  input  logic                      i_bvalid,
  input  logic                      i_bready,
  input  logic [1:0]                i_bresp,
  output logic                      o_busy,
  output logic [7:0]                o_err_cnt
);
  localparam int PTR_W  = $clog2(DEPTH);
  localparam int CNT_W  = PTR_W + 1;
  localparam int STRB_W = DATA_W / 8;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_RESP} state_t;

  state_t             state_reg;
  logic [PTR_W-1:0]   wr_ptr_reg;
  logic [PTR_W-1:0]   rd_ptr_reg;
  logic [CNT_W-1:0]   count_reg;
  logic [CNT_W-1:0]   count_next;
  logic               push_ok;
  logic               pop;

  logic [ADDR_W-1:0]  addr_mem [DEPTH];
  logic [DATA_W-1:0]  data_mem [DEPTH];
  logic [STRB_W-1:0]  strb_mem [DEPTH];

  assign o_full  = (count_reg == CNT_W'(DEPTH));
  assign o_empty = (count_reg == '0);
  assign o_count = count_reg;
  assign o_busy  = (state_reg != IDLE);

  // A push while full is dropped even when a pop happens in the same cycle.
  assign push_ok = i_push && !o_full;
  assign pop     = (state_reg == WAIT_RESP) && i_bvalid && i_bready;

  always_comb begin
    count_next = count_reg;
    case ({push_ok, pop})
      2'b10:   count_next = count_reg + CNT_W'(1);
      2'b01:   count_next = count_reg - CNT_W'(1);
      default: count_next = count_reg;
    endcase
  end

  // Storage has no reset so it can map onto RAM; only pointers/count are cleared.
  always_ff @(posedge i_clk) begin
    if (push_ok) begin
      addr_mem[wr_ptr_reg] <= i_addr;
      data_mem[wr_ptr_reg] <= i_data;
      strb_mem[wr_ptr_reg] <= i_strb;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
      o_ovf      <= 1'b0;
    end else begin
      count_reg <= count_next;
      if (push_ok)
        wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
      if (pop)
        rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
      if (i_push && o_full)
        o_ovf <= 1'b1;
    end
  end

  // Head stays in the FIFO until its B handshake; the command regs hold it meanwhile.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_reg <= IDLE;
      o_wr      <= 1'b0;
      o_addrin  <= '0;
      o_din     <= '0;
      o_strb    <= '0;
    end else begin
      o_wr <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (count_reg != '0) begin
            o_addrin  <= addr_mem[rd_ptr_reg];
            o_din     <= data_mem[rd_ptr_reg];
            o_strb    <= strb_mem[rd_ptr_reg];
            state_reg <= ISSUE;
          end
        end
        ISSUE: begin
          o_wr      <= 1'b1;
          state_reg <= WAIT_RESP;
        end
        WAIT_RESP: begin
          if (pop)
            state_reg <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

`ifdef AXI_WR_CMD_ERR_CNT_EN
  logic [7:0] err_cnt_reg;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst)
      err_cnt_reg <= 8'd0;
    else if (pop && (i_bresp != 2'b00) && (err_cnt_reg != 8'hFF))
      err_cnt_reg <= err_cnt_reg + 8'd1;
  end

  assign o_err_cnt = err_cnt_reg;
`else
  logic unused_bresp;
  assign unused_bresp = ^i_bresp;
  assign o_err_cnt    = 8'd0;
`endif

endmodule

// File: tb/tb_axi_wr_cmd_queue.sv
module tb_axi_wr_cmd_queue;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        push = 1'b0;
    logic [31:0] addr = '0;
    logic [31:0] data = '0;
    logic [3:0]  strb = '0;
    logic        full, empty, ovf, wr, busy;
    logic [2:0]  count;
    logic [31:0] addrin, din;
    logic [3:0]  strb_o;
    logic        bvalid = 1'b0;
    logic        bready = 1'b0;
    logic [1:0]  bresp = 2'b00;
    logic [7:0]  err_cnt;

    int checks   = 0;
    int failures = 0;
    int wr_cnt   = 0;
    logic [31:0] issued_addr [$];
    logic [31:0] issued_data [$];

    always #5 clk = ~clk;

    axi_wr_cmd_queue #(.DEPTH(4), .ADDR_W(32), .DATA_W(32)) dut (
        .i_clk(clk), .i_rst(rst), .i_push(push), .i_addr(addr), .i_data(data),
        .i_strb(strb), .o_full(full), .o_empty(empty), .o_count(count),
        .o_ovf(ovf), .o_wr(wr), .o_addrin(addrin), .o_din(din), .o_strb(strb_o),
        .i_bvalid(bvalid), .i_bready(bready), .i_bresp(bresp), .o_busy(busy),
        .o_err_cnt(err_cnt)
    );

    always @(negedge clk) begin
        if (wr) begin
            wr_cnt++;
            issued_addr.push_back(addrin);
            issued_data.push_back(din);
            $display("issue #%0d addr=%0h data=%0h strb=%0h", wr_cnt, addrin, din, strb_o);
        end
    end

    task automatic check(input string tag, input logic ok, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (ok !== 1'b1) begin
            failures++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_push(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        push = 1'b1; addr = a; data = d; strb = s;
        step();
        push = 1'b0;
        $display("push addr=%0h data=%0h strb=%0h count=%0d full=%0b ovf=%0b", a, d, s, count, full, ovf);
    endtask

    task automatic respond(input logic [1:0] r);
        bvalid = 1'b1; bready = 1'b1; bresp = r;
        step();
        bvalid = 1'b0; bready = 1'b0; bresp = 2'b00;
        $display("resp bresp=%0b count=%0d busy=%0b", r, count, busy);
    endtask

    task automatic wait_wr(input int target);
        for (int i = 0; i < 30 && wr_cnt < target; i++) step();
        check("wr_timeout", wr_cnt >= target, wr_cnt, target);
    endtask

    initial begin
        logic [7:0] exp_err;
`ifdef AXI_WR_CMD_ERR_CNT_EN
        exp_err = 8'd2;
`else
        exp_err = 8'd0;
`endif
        step(); step();
        check("rst_empty", empty === 1'b1, empty, 1'b1);
        check("rst_full", full === 1'b0, full, 1'b0);
        check("rst_count", count === 3'd0, count, 3'd0);
        check("rst_ovf", ovf === 1'b0, ovf, 1'b0);
        check("rst_wr", wr === 1'b0, wr, 1'b0);
        check("rst_busy", busy === 1'b0, busy, 1'b0);
        check("rst_addrin", addrin === 32'h0, addrin, 32'h0);
        check("rst_err", err_cnt === 8'd0, err_cnt, 8'd0);
        rst = 1'b0;
        step();

        do_push(32'h10, 32'h5, 4'hF);
        check("p1_count", count === 3'd1, count, 3'd1);
        check("p1_empty", empty === 1'b0, empty, 1'b0);
        check("p1_wr_k", wr === 1'b0, wr, 1'b0);
        step();
        check("p1_wr_k1", wr === 1'b0, wr, 1'b0);
        check("p1_busy", busy === 1'b1, busy, 1'b1);
        check("p1_latched", addrin === 32'h10, addrin, 32'h10);
        step();
        check("p1_wr_k2", wr === 1'b1, wr, 1'b1);
        check("p1_addrin", addrin === 32'h10, addrin, 32'h10);
        check("p1_din", din === 32'h5, din, 32'h5);
        check("p1_strb", strb_o === 4'hF, strb_o, 4'hF);
        step();
        check("p1_wr_k3", wr === 1'b0, wr, 1'b0);
        check("p1_count_hold", count === 3'd1, count, 3'd1);
        respond(2'b00);
        check("p1_count_done", count === 3'd0, count, 3'd0);
        check("p1_empty_done", empty === 1'b1, empty, 1'b1);
        check("p1_busy_done", busy === 1'b0, busy, 1'b0);
        check("p1_wr_total", wr_cnt === 1, wr_cnt, 1);

        for (int i = 0; i < 4; i++)
            do_push(32'h100 + i, 32'hA0 + i, 4'h1 << i);
        check("fill_full", full === 1'b1, full, 1'b1);
        check("fill_count", count === 3'd4, count, 3'd4);
        check("fill_ovf", ovf === 1'b0, ovf, 1'b0);
        do_push(32'h104, 32'hA4, 4'hF);
        check("ovf_set", ovf === 1'b1, ovf, 1'b1);
        check("ovf_count", count === 3'd4, count, 3'd4);
        wait_wr(2);

        bvalid = 1'b1; bready = 1'b0; bresp = 2'b00;
        repeat (20) step();
        bvalid = 1'b0;
        check("hold_busy", busy === 1'b1, busy, 1'b1);
        check("hold_wr_cnt", wr_cnt === 2, wr_cnt, 2);
        check("hold_addrin", addrin === 32'h100, addrin, 32'h100);
        check("hold_din", din === 32'hA0, din, 32'hA0);
        check("hold_count", count === 3'd4, count, 3'd4);

        respond(2'b10);
        wait_wr(3); respond(2'b00);
        wait_wr(4); respond(2'b11);
        wait_wr(5); respond(2'b00);
        repeat (5) step();
        check("drain_wr_cnt", wr_cnt === 5, wr_cnt, 5);
        check("drain_empty", empty === 1'b1, empty, 1'b1);
        check("err_cnt", err_cnt === exp_err, err_cnt, exp_err);
        for (int i = 0; i < 4; i++) begin
            check("order_addr", issued_addr[i+1] === 32'h100 + i, issued_addr[i+1], 32'h100 + i);
            check("order_data", issued_data[i+1] === 32'hA0 + i, issued_data[i+1], 32'hA0 + i);
        end

        for (int i = 0; i < 3; i++)
            do_push(32'h300 + i, 32'hC0 + i, 4'hF);
        wait_wr(6);
        #2 rst = 1'b1;
        #1;
        check("arst_count", count === 3'd0, count, 3'd0);
        check("arst_empty", empty === 1'b1, empty, 1'b1);
        check("arst_wr", wr === 1'b0, wr, 1'b0);
        check("arst_busy", busy === 1'b0, busy, 1'b0);
        check("arst_err", err_cnt === 8'd0, err_cnt, 8'd0);
        step();
        rst = 1'b0;
        repeat (10) step();
        check("arst_no_issue", wr_cnt === 6, wr_cnt, 6);
        check("arst_idle", busy === 1'b0, busy, 1'b0);

        for (int i = 0; i < 4; i++)
            do_push(32'h400 + i, 32'hD0 + i, 4'h3);
        check("sim_full", full === 1'b1, full, 1'b1);
        check("sim_ovf0", ovf === 1'b0, ovf, 1'b0);
        wait_wr(7);
        push = 1'b1; addr = 32'h4FF; data = 32'hFF; strb = 4'hF;
        bvalid = 1'b1; bready = 1'b1; bresp = 2'b00;
        step();
        push = 1'b0; bvalid = 1'b0; bready = 1'b0;
        check("sim_ovf1", ovf === 1'b1, ovf, 1'b1);
        check("sim_count", count === 3'd3, count, 3'd3);
        check("sim_full0", full === 1'b0, full, 1'b0);
        wait_wr(8); respond(2'b00);
        wait_wr(9); respond(2'b00);
        wait_wr(10); respond(2'b00);
        repeat (6) step();
        check("sim_wr_cnt", wr_cnt === 10, wr_cnt, 10);
        check("sim_empty", empty === 1'b1, empty, 1'b1);
        for (int i = 0; i < 4; i++)
            check("sim_order", issued_addr[6+i] === 32'h400 + i, issued_addr[6+i], 32'h400 + i);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "global timeout");
    end
endmodule

// File: doc/axi_wr_cmd_queue.md
# axi_wr_cmd_queue

Buffers write commands (address, data, strobe) from a local requester and feeds them one at a time into the `m_axi` write master. It sits directly upstream of `m_axi`: it drives `i_wr`/`i_addrin`/`i_din`/`i_strb` and retires each command only when the B-channel handshake completes. Commands are queued in a small circular FIFO so the requester can post bursts without waiting on slave latency.

## Interface
- `DEPTH`, 4: FIFO entries; power of two, at least 2.
- `ADDR_W`, 32: address width.
- `DATA_W`, 32: data width; strobe width is `DATA_W/8`.
- `i_clk`  in  1  clock; all logic on the rising edge.
- `i_rst`  in  1  asynchronous reset, active-high.
- `i_push`  in  1  enqueue request from the requester.
- `i_addr`  in  ADDR_W  command address.
- `i_data`  in  DATA_W  command write data.
- `i_strb`  in  DATA_W/8  command byte strobes.
- `o_full`  out  1  FIFO holds DEPTH entries.
- `o_empty`  out  1  FIFO holds 0 entries.
- `o_count`  out  $clog2(DEPTH)+1  occupancy.
- `o_ovf`  out  1  sticky: a push was dropped while full.
- `o_wr`  out  1  to `m_axi` `i_wr`: one-cycle issue pulse.
- `o_addrin`  out  ADDR_W  to `m_axi` `i_addrin`.
- `o_din`  out  DATA_W  to `m_axi` `i_din`.
- `o_strb`  out  DATA_W/8  to `m_axi` `i_strb`.
- `i_bvalid`  in  1  monitored `m_axi_bvalid`.
- `i_bready`  in  1  monitored `m_axi_bready`.
- `i_bresp`  in  2  monitored `m_axi_bresp`.
- `o_busy`  out  1  a command is in flight (ISSUE or WAIT_RESP).
- `o_err_cnt`  out  8  count of non-OKAY responses (see Configuration).

## Operation
- FIFO: write pointer, read pointer, and count register. Pointers wrap modulo DEPTH.
- Push rule: a push is accepted when `i_push && !o_full`. A push with `o_full` set is dropped and sets `o_ovf`. The push is dropped even if a pop occurs in the same cycle.
- Simultaneous push and pop with the FIFO not full: count is unchanged and both pointers advance.
- FSM states: IDLE, ISSUE, WAIT_RESP.
  - IDLE: if count > 0, latch the head entry into `o_addrin`/`o_din`/`o_strb`, then go to ISSUE.
  - ISSUE: `o_wr`=1 for exactly this cycle, then go to WAIT_RESP.
  - WAIT_RESP: on `i_bvalid && i_bready`, pop the head, check `i_bresp`, and go to IDLE. Otherwise stay in WAIT_RESP indefinitely; there is no timeout.
- `o_addrin`/`o_din`/`o_strb` are registered and stay stable from ISSUE until the next latch in IDLE. Later pushes never disturb the in-flight command.
- The head entry remains counted in `o_count` until its response completes.
- `o_busy` = (state != IDLE).

## Timing
- Reset values:
  - state IDLE; pointers and count 0.
  - `o_empty`=1; `o_full`=0; `o_ovf`=0; `o_wr`=0; `o_busy`=0.
  - `o_addrin`/`o_din`/`o_strb`=0; `o_err_cnt`=0.
- Reset asserted mid-operation aborts the in-flight command and discards all queued entries. No response is awaited after reset release.
- Latency: a push accepted at edge k into an empty, idle queue latches the entry at edge k+1. `o_wr` is high during the cycle between edges k+2 and k+3.
- Back-to-back commands: a response handshake at edge r gives IDLE in the next cycle. The next `o_wr` pulse is high between edges r+2 and r+3. Minimum issue spacing after a response is 3 cycles.
- `o_full`, `o_empty`, and `o_count` reflect the registered count. They update on the edge of a push or pop.
- `i_bvalid` high without `i_bready`, or outside WAIT_RESP, is ignored.

## Configuration
- Macro: `AXI_WR_CMD_ERR_CNT_EN`.
- Defined:
  - `o_err_cnt` increments by 1 on each completed response with `i_bresp != 2'b00`.
  - It saturates at 255.
  - It is cleared only by reset.
- Undefined: the counter logic is omitted and `o_err_cnt` is tied to 8'd0.

## Test plan
- Reset, then a single push (addr 0x10, data 0x5, strb 4'hF) -> `o_wr` pulses once, 2 cycles after the push, with those values on `o_addrin`/`o_din`/`o_strb`. `o_count` stays 1 until B handshake, then 0; `o_empty`=1.
- Push 4 commands back-to-back with DEPTH=4 -> `o_full`=1 after the 4th. A 5th push sets `o_ovf`=1 and is not issued. Exactly 4 `o_wr` pulses occur, in push order, each after the prior response.
- Hold `i_bready`=0 for 20 cycles while `i_bvalid`=1 -> state stays WAIT_RESP. Outputs stay stable and there is no second `o_wr`.
- Push while full in the same cycle as a response pop -> push dropped, `o_ovf`=1, count goes 4 -> 3.
- With macro defined: 3 responses with bresp 2'b10, 2'b00, 2'b11 -> `o_err_cnt`=2. Without the macro -> `o_err_cnt`=0.
- Assert `i_rst` during WAIT_RESP with 3 entries queued -> immediately count 0, `o_empty`=1, `o_wr`=0, `o_busy`=0. No `o_wr` after release until a new push.
